// File: rtl/dvsd_pe_arbiter.sv
// Eight-requester arbiter with fixed-priority or round-robin selection,
// a registered one-hot grant and a MAX_HOLD-cycle grant hold limit.
module dvsd_pe_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       rr_en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gs,
    output logic       eno,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] gnt_id_q, gnt_id_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic       eno_q, eno_d;
    logic       timeout_q, timeout_d;

    logic [2:0] fixed_id, rr_id, win_id;
    logic       release_w, limit_w;

    // Later loop iterations overwrite earlier ones, so the loops run from the
    // lowest-priority candidate to the highest.
    always_comb begin
        logic [2:0] idx;
        idx      = '0;
        fixed_id = '0;
        rr_id    = ptr_q;
        for (int i = 0; i < 8; i++) begin
            if (req[i]) fixed_id = 3'(i);
        end
        for (int off = 8; off >= 1; off--) begin
            idx = ptr_q - 3'(off);
            if (req[idx]) rr_id = idx;
        end
        win_id = rr_en ? rr_id : fixed_id;
    end

    assign release_w = !req[gnt_id_q] || !en;
    assign limit_w   = (hold_q == HOLD_LAST);

    // NOTE: every output of this block is assigned a default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        eno_d     = en && (req == 8'h00) && (state_q == IDLE);

        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (en && (req != 8'h00)) begin
                    state_d  = GRANT;
                    gnt_d    = 8'b1 << win_id;
                    gnt_id_d = win_id;
                    ptr_d    = win_id;
                    hold_d   = '0;
                end
            end
            GRANT: begin
                if (release_w || limit_w) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    // A release on the limit cycle is a normal end, not a timeout.
                    timeout_d = limit_w && !release_w;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values of its peers; reset is synchronous to clk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            eno_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            eno_q     <= eno_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign gs      = |gnt_q;
    assign eno     = eno_q;
    assign timeout = timeout_q;

endmodule
